// File: rtl/spike_pkg.sv
// Shared widths, field offsets, refractory FSM encoding and the mean clamp
// used by the spike event packer.
package spike_pkg;

  localparam int EVT_W     = 32;  // packed event word width
  localparam int TS_W      = 16;  // timestamp field width
  localparam int MEAN_W    = 16;  // saturated mean field width
  localparam int IN_MEAN_W = 31;  // mean width on the detector stream

  // Field offsets inside the detector word and the event word
  localparam int FLAG_BIT  = 31;
  localparam int TS_LSB    = 16;
  localparam int MEAN_LSB  = 0;

  typedef enum logic {
    ARMED = 1'b0,
    HOLD  = 1'b1
  } refr_state_t;

  // Unsigned clamp of the 31-bit running mean into 16 bits
  function automatic logic [MEAN_W-1:0] sat16(input logic [IN_MEAN_W-1:0] value);
    logic [IN_MEAN_W-1:0] v;
    v = value;
    if (v > 31'h0000_FFFF) return 16'hFFFF;
    return v[MEAN_W-1:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers. The head entry is presented
// combinationally; an empty FIFO presents zero.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             wr_accept
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_do_rd;
  logic w_do_wr;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_rd   = rd_en && !empty;
  // A full FIFO still takes a write when the head leaves in the same cycle
  assign wr_accept = !full || w_do_rd;
  assign w_do_wr   = wr_en && wr_accept;
  assign rd_data   = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // Pointer advance on accepted writes and reads
  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // blocking = here would let one pointer's update leak into another's.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage write
  // NOTE: the array is deliberately not reset; the pointers alone define
  // which entries are live, and a reset here would forbid RAM inference.
  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/spike_event_packer.sv
// Refractory-filtered spike packer: timestamps accepted spikes, queues them
// in a FIFO and drains them through an AXI-Stream master with drop accounting.
module spike_event_packer
  import spike_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int REFRACT = 8,
  parameter int BURST   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic [31:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic [31:0] spike_count,
  output logic [15:0] drop_count,
  output logic        overflow
);

  localparam int REF_W = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

  refr_state_t      r_state;
  logic [REF_W-1:0] r_ref_cnt;
  logic [31:0]      r_ts_cnt;
  logic [7:0]       r_burst_cnt;
  logic [31:0]      r_spike_count;
  logic [15:0]      r_drop_count;
  logic             r_overflow;

  logic              w_flag;
  logic [MEAN_W-1:0] w_mean_sat;
  logic              w_accept;
  logic              w_push_ok;
  logic              w_pushed;
  logic              w_dropped;
  logic              w_tlast;
  logic [EVT_W-1:0]  w_evt_word;
  logic [EVT_W:0]    w_head;
  logic              w_full;
  logic              w_empty;

  assign w_flag     = s_data[FLAG_BIT];
  assign w_mean_sat = sat16(s_data[IN_MEAN_W-1:0]);
  assign w_accept   = s_valid && w_flag && (r_state == ARMED);
  assign w_pushed   = w_accept && w_push_ok;
  assign w_dropped  = w_accept && !w_push_ok;
  assign w_tlast    = (r_burst_cnt == 8'(BURST - 1));
  assign w_evt_word = {r_ts_cnt[TS_W-1:0], w_mean_sat};

  assign m_tvalid    = !w_empty;
  assign m_tdata     = w_head[EVT_W-1:0];
  assign m_tlast     = w_head[EVT_W];
  assign spike_count = r_spike_count;
  assign drop_count  = r_drop_count;
  assign overflow    = r_overflow;

  // Refractory FSM: every valid sample in HOLD counts down, flags are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ARMED;
      r_ref_cnt <= '0;
    end else begin
      case (r_state)
        ARMED: begin
          if (w_accept && (REFRACT > 0)) begin
            r_state   <= HOLD;
            r_ref_cnt <= REF_W'(REFRACT);
          end
        end
        HOLD: begin
          if (s_valid) begin
            r_ref_cnt <= r_ref_cnt - REF_W'(1);
            if (r_ref_cnt == REF_W'(1)) r_state <= ARMED;
          end
        end
        default: r_state <= ARMED;
      endcase
    end
  end

  // Sample timestamp, event/drop accounting and burst position
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ts_cnt      <= '0;
      r_spike_count <= '0;
      r_drop_count  <= '0;
      r_overflow    <= 1'b0;
      r_burst_cnt   <= '0;
    end else begin
      if (s_valid)  r_ts_cnt      <= r_ts_cnt + 32'd1;
      if (w_accept) r_spike_count <= r_spike_count + 32'd1;
      if (w_dropped) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
      end
      // The burst position only moves when the event actually lands
      if (w_pushed) r_burst_cnt <= w_tlast ? 8'd0 : r_burst_cnt + 8'd1;
    end
  end

  sync_fifo #(
    .WIDTH (EVT_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (w_accept),
    .wr_data   ({w_tlast, w_evt_word}),
    .rd_en     (m_tready),
    .rd_data   (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .wr_accept (w_push_ok)
  );

endmodule

// File: tb/tb_spike_event_packer.sv
// Randomised scoreboard bench for spike_event_packer. The stimulus side
// predicts each event from the filtering/queueing rules and queues it; an
// independent monitor pops and compares on every output handshake.
module tb_spike_event_packer;

  localparam int DEPTH   = 16;
  localparam int REFRACT = 8;
  localparam int BURST   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_data;
  logic        s_valid;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic [31:0] spike_count;
  logic [15:0] drop_count;
  logic        overflow;

  spike_event_packer #(
    .DEPTH   (DEPTH),
    .REFRACT (REFRACT),
    .BURST   (BURST)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tlast     (m_tlast),
    .spike_count (spike_count),
    .drop_count  (drop_count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        tlast;
    logic [31:0] data;
  } evt_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  evt_t exp_q[$];

  // Reference model state
  int unsigned m_ts;
  bit          m_have_acc;
  int unsigned m_last_acc;
  int          m_occ;
  int unsigned m_spikes;
  int          m_drops;
  bit          m_ovf;
  int unsigned m_pushed;

  // Monitor observations
  int          beats;
  int          tlast_beats;
  logic [31:0] last_beat_data;
  logic        last_beat_tlast;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    exp_q.delete();
    m_ts = 0; m_have_acc = 0; m_last_acc = 0; m_occ = 0;
    m_spikes = 0; m_drops = 0; m_ovf = 0; m_pushed = 0;
    beats = 0; tlast_beats = 0; last_beat_data = '0; last_beat_tlast = 1'b0;
  endfunction

  // Monitor: compare every accepted beat against the oldest predicted event
  initial begin
    evt_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && m_tvalid === 1'b1 && m_tready === 1'b1) begin
        beats++;
        if (m_tlast) tlast_beats++;
        last_beat_data  = m_tdata;
        last_beat_tlast = m_tlast;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL beat_unexpected: got tdata 0x%0h, expected no beat", m_tdata);
        end else begin
          e = exp_q.pop_front();
          check("beat_tdata", m_tdata, e.data);
          check("beat_tlast", m_tlast, e.tlast);
        end
      end
    end
  end

  // One sample cycle: check state left by the previous edge, then drive and predict
  task automatic step(input bit v, input bit f, input logic [30:0] mean, input bit rdy);
    bit          pop;
    bit          ok;
    int unsigned ts_now;
    int unsigned msat;
    evt_t        e;
    @(posedge clk); #1;
    check("tvalid", m_tvalid, (m_occ > 0));
    check("spike_count", spike_count, m_spikes);
    check("drop_count", drop_count, m_drops);
    check("overflow", overflow, m_ovf);
    s_valid  = v;
    s_data   = {f, mean};
    m_tready = rdy;
    pop = (m_occ > 0) && rdy;
    ok  = 0;
    if (v) begin
      ts_now = m_ts;
      m_ts++;
      // Accepted if no accepted spike in the REFRACT samples before this one
      if (f && (!m_have_acc || (ts_now - m_last_acc) > REFRACT)) begin
        m_spikes++;
        m_have_acc = 1;
        m_last_acc = ts_now;
        if (m_occ < DEPTH || pop) begin
          msat    = (mean > 31'd65535) ? 65535 : int'(mean);
          e.tlast = ((m_pushed % BURST) == BURST - 1);
          e.data  = ((ts_now % 65536) << 16) | msat;
          exp_q.push_back(e);
          m_pushed++;
          ok = 1;
        end else begin
          if (m_drops < 65535) m_drops++;
          m_ovf = 1;
        end
      end
    end
    m_occ = m_occ + int'(ok) - int'(pop);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_tready = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check("rst_tvalid", m_tvalid, 1'b0);
    check("rst_tdata", m_tdata, 32'h0);
    check("rst_tlast", m_tlast, 1'b0);
    check("rst_spike_count", spike_count, 32'h0);
    check("rst_drop_count", drop_count, 16'h0);
    check("rst_overflow", overflow, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_tready = 1'b0;
    model_reset();

    // Single spike after reset: ts 5, mean 0x120
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 31'(i * 3), 1);
    step(1, 1, 31'h120, 1);
    step(0, 0, 0, 1);
    check("single_tvalid", m_tvalid, 1'b1);
    check("single_tdata", m_tdata, 32'h0005_0120);
    repeat (3) step(0, 0, 0, 1);
    check("single_spikes", spike_count, 32'd1);
    check("single_beats", beats, 1);

    // Refractory window: flags at 10, 12, 18, 19 -> events at 10 and 19
    do_reset();
    for (int t = 0; t <= 20; t++)
      step(1, (t == 10 || t == 12 || t == 18 || t == 19), 31'(t), 1);
    repeat (3) step(0, 0, 0, 1);
    check("refr_beats", beats, 2);
    check("refr_last_ts", last_beat_data[31:16], 16'd19);
    check("refr_drops", drop_count, 16'd0);

    // Saturated mean and tlast on the 8th event only
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step(1, 1, 31'h7FFF_FFFF, 1);
      repeat (8) step(1, 0, 31'd5, 1);
    end
    repeat (3) step(0, 0, 0, 1);
    check("sat_beats", beats, 8);
    check("sat_tlast_beats", tlast_beats, 1);
    check("sat_last_tlast", last_beat_tlast, 1'b1);
    check("sat_last_data", last_beat_data, 32'h003F_FFFF);

    // Overflow with the sink stalled, then full with simultaneous push/pop
    do_reset();
    for (int k = 0; k < 20; k++) begin
      step(1, 1, 31'(k), 0);
      repeat (8) step(1, 0, 0, 0);
    end
    step(0, 0, 0, 0);
    check("ovf_drops", drop_count, 16'd4);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_spikes", spike_count, 32'd20);
    check("ovf_beats_stalled", beats, 0);
    step(1, 1, 31'd7, 1);
    step(0, 0, 0, 0);
    check("full_pushpop_drops", drop_count, 16'd4);
    check("full_pushpop_beats", beats, 1);
    repeat (24) step(0, 0, 0, 1);
    check("full_drain_beats", beats, 17);

    // Asynchronous reset with five entries queued
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(1, 1, 31'(k + 1), 0);
      repeat (8) step(1, 0, 0, 0);
    end
    step(0, 0, 0, 0);
    check("areset_pre_tvalid", m_tvalid, 1'b1);
    @(negedge clk); #2;
    rst = 1'b1; s_valid = 1'b0; m_tready = 1'b0;
    model_reset();
    #1;
    check("areset_tvalid", m_tvalid, 1'b0);
    check("areset_tdata", m_tdata, 32'h0);
    check("areset_spikes", spike_count, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(1, 1, 31'h42, 1);
    step(0, 0, 0, 1);
    check("areset_next_tdata", m_tdata, 32'h0000_0042);
    repeat (2) step(0, 0, 0, 1);
    check("areset_next_spikes", spike_count, 32'd1);

    // Randomised traffic with a mixed ready pattern
    do_reset();
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) != 0 ? 31'($urandom()) : 31'($urandom_range(0, 70000)),
           $urandom_range(0, 9) < 5);
    repeat (DEPTH + 8) step(0, 0, 0, 1);
    check("rand_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spike_event_packer.md
# spike_event_packer

Downstream consumer of the running-mean spike detector. Takes its 32-bit result stream (bit 31 = spike flag, bits 30:0 = running mean) and applies a sample-counted refractory filter. Qualifying spikes are packed with a 16-bit sample timestamp and queued in a small FIFO. The queue drains through an AXI-Stream master towards the DMA/PS side, with drop accounting when the queue overflows.

## Interface
- DEPTH, 16: FIFO entries; power of two, 4..64.
- REFRACT, 8: valid samples ignored after an accepted spike; 0 disables the filter.
- BURST, 8: every BURST-th event carries m_tlast; 1..255.
- CLK  in  1  single clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- s_data  in  32  detector output; [31] spike flag, [30:0] mean.
- s_valid  in  1  detector valid, m_axis_valid upstream. There is no back-pressure: a sample is consumed on every cycle s_valid=1.
- m_tdata  out  32  event word {ts[15:0], mean_sat[15:0]}.
- m_tvalid  out  1  FIFO not empty.
- m_tready  in  1  downstream ready.
- m_tlast  out  1  burst boundary marker for the head entry.
- spike_count  out  32  accepted events, wraps.
- drop_count  out  16  events lost to a full FIFO, saturates at 0xFFFF.
- overflow  out  1  sticky; set on the first drop, cleared only by RST.

## Operation
- **Sample counter:** ts_cnt (32 bit) increments on every s_valid and wraps. The timestamp of a sample is the ts_cnt value before its increment, so the first sample after reset is ts=0. ts[15:0] is packed.
- **mean_sat:** s_data[30:0] clamped to 0xFFFF. The mean is unsigned: bit 31 is the flag, never a sign.
- **Refractory FSM**, two states:
  - ARMED: on s_valid with flag=1, the spike is accepted. If REFRACT>0, go to HOLD and load ref_cnt=REFRACT.
  - HOLD: each s_valid decrements ref_cnt, whatever the flag value. When a sample arrives with ref_cnt=1, the counter reaches 0 and the FSM returns to ARMED. Flags seen in HOLD are discarded, not counted, and not treated as drops.
  - REFRACT=0: the FSM stays in ARMED, so every flagged sample is accepted.
- **Accepted spike:**
  - spike_count +1.
  - Push the event word.
  - Compute the tlast bit from burst_cnt (0..BURST-1). tlast=1 when burst_cnt=BURST-1, after which burst_cnt wraps to 0. burst_cnt advances only on successful pushes.
- **FIFO:** DEPTH entries of 33 bits (tdata + tlast). Pointers are log2(DEPTH)+1 bits so full and empty can be told apart.
  - Push is blocked when full, unless a pop happens in the same cycle.
  - A blocked push does the following: drop_count +1 (saturating), overflow=1, spike_count still +1, refractory still entered, burst_cnt unchanged.
- **Pop:** m_tvalid && m_tready. m_tdata and m_tlast always reflect the head entry and are stable while m_tvalid=1 and m_tready=0.

## Timing
- Reset values: m_tvalid=0, m_tdata=0, m_tlast=0, spike_count=0, drop_count=0, overflow=0. Internally: FSM=ARMED, ts_cnt=0, burst_cnt=0, ref_cnt=0, pointers=0.
- RST asserted mid-operation clears every register immediately. FIFO contents are discarded, and any transfer in flight is abandoned with no completion.
- Latency: a spike sampled in cycle N is written at the edge closing N, and m_tvalid is high in cycle N+1 if the FIFO was empty. There is no combinational bypass from s_data to m_tdata.
- Counters (spike_count, drop_count, overflow) update at the same edge as the push.
- Throughput is one push and one pop per cycle, simultaneously. When empty with push-only, no pop is possible that cycle.
- Full with simultaneous push and pop: both succeed, occupancy stays at DEPTH, no drop.
- m_tready low indefinitely: after DEPTH further events, every accepted spike becomes a drop.
- ts wrap from 0xFFFF to 0x0000 in the packed field is expected. ts_cnt wrap at 2^32 is silent.

## Structure
- Package spike_pkg holds:
  - EVT_W=32, TS_W=16, MEAN_W=16.
  - Field offsets.
  - The FSM enum {ARMED, HOLD}.
  - A sat16 function.
- One sub-module, sync_fifo: parameterised width/depth, registered pointers, and full/empty plus read/write enables. The packer owns the FSM, the counters and the packing logic.

## Test plan
- **Single spike after reset:** 5 samples with flag=0, then flag=1 with mean=0x120 at sample 5, m_tready=1 → one beat m_tdata=0x0005_0120, m_tvalid in the cycle after the sample, spike_count=1.
- **Refractory, REFRACT=8:** flags at samples 10, 12, 18, 19 → events at ts 10 and 19 only. Samples 12 and 18 are suppressed (HOLD covers 11..18), and drop_count=0.
- **Saturation and tlast, BURST=8:** mean=0x7FFF_FFFF → mean_sat=0xFFFF. Eight accepted events give m_tlast=1 on the 8th beat only.
- **Overflow, m_tready=0, DEPTH=16, REFRACT=0:** 20 flagged samples → 16 entries held, drop_count=4, overflow=1, spike_count=20. Release m_tready → exactly 16 beats with ts 0..15.
- **Full with simultaneous push/pop:** FIFO full, m_tready=1 and flagged sample in the same cycle → occupancy stays at 16, drop_count unchanged.
- **Async reset mid-burst:** assert RST between clock edges with 5 entries queued → m_tvalid=0 immediately. After release the next spike carries ts=0 and spike_count=1.
